// File: rtl/pc_reconverge.sv
// pc_reconverge
//   Per-core thread-PC unifier. It collects each thread's next PC after an
//   instruction and picks the single PC the core fetches next. It also
//   produces the mask of threads that execute that PC. Scheduling is min-PC:
//   the lowest PC among live threads runs first, and equal PCs merge, so
//   divergent paths reconverge without a stack. Per-thread RET retires a
//   thread, and done reports that every enabled thread has returned.
//
// Ports
//   clk               in   clock
//   reset             in   synchronous, active-high reset
//   i_start           in   block launch; loads the live set, restarts from any state
//   i_thread_count    in   enabled threads for the block (0..T), sampled on i_start
//   i_update          in   next PCs valid pulse; honored only while o_pc_valid
//   i_thread_next_pc  in   thread i next PC at [i*A +: A]
//   i_thread_ret      in   per-thread RET flag
//   o_current_pc      out  PC the core fetches
//   o_active_mask     out  threads executing o_current_pc
//   o_pc_valid        out  o_current_pc / o_active_mask are valid
//   o_diverged        out  o_pc_valid and the active mask differs from the live set
//   o_done            out  all enabled threads have returned
module pc_reconverge #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               i_start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]                 i_thread_count,
    input  logic                                               i_update,
    input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] i_thread_next_pc,
    input  logic [THREADS_PER_BLOCK-1:0]                       i_thread_ret,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   o_current_pc,
    output logic [THREADS_PER_BLOCK-1:0]                       o_active_mask,
    output logic                                               o_pc_valid,
    output logic                                               o_diverged,
    output logic                                               o_done
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int KW = $clog2(T);
    localparam int CW = KW + 1;
    localparam logic [KW-1:0] K_LAST = KW'(T - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_READY, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [A-1:0]   r_thread_pc [T];
    logic [T-1:0]   r_live;
    logic [KW-1:0]  r_k;
    logic [A-1:0]   r_min_pc;
    logic [T-1:0]   r_mask;
    logic           r_found;
    logic [A-1:0]   r_current_pc;
    logic [T-1:0]   r_active_mask;

    logic [T-1:0]   w_live_init;
    logic [A-1:0]   w_scan_pc;
    logic           w_found_nxt;
    logic [A-1:0]   w_min_nxt;
    logic [T-1:0]   w_mask_nxt;

    // Low i_thread_count bits set; i_thread_count may equal T, so build it
    // per bit instead of shifting a T-bit one.
    always_comb begin
        for (int i = 0; i < T; i++) begin
            w_live_init[i] = (CW'(i) < i_thread_count);
        end
    end

    // One scan step at index r_k, folded into the running min/mask.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_scan_pc   = r_thread_pc[r_k];
        w_found_nxt = r_found;
        w_min_nxt   = r_min_pc;
        w_mask_nxt  = r_mask;
        if (r_live[r_k]) begin
            if (!r_found || (w_scan_pc < r_min_pc)) begin
                w_found_nxt = 1'b1;
                w_min_nxt   = w_scan_pc;
                w_mask_nxt  = T'(1) << r_k;
            end else if (w_scan_pc == r_min_pc) begin
                w_mask_nxt  = r_mask | (T'(1) << r_k);
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; start wins over everything else.
    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = (i_thread_count == '0) ? S_DONE : S_SCAN;
        end else begin
            case (r_state)
                S_READY: if (i_update) w_state_nxt = S_SCAN;
                S_SCAN:  if (r_k == K_LAST) w_state_nxt = w_found_nxt ? S_READY : S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Datapath.
    // NOTE: the thread PC file is only T entries, so it is reset along with
    // the control state; start rewrites it anyway before it is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < T; i++) r_thread_pc[i] <= '0;
            r_live        <= '0;
            r_k           <= '0;
            r_min_pc      <= '0;
            r_mask        <= '0;
            r_found       <= 1'b0;
            r_current_pc  <= '0;
            r_active_mask <= '0;
        end else if (i_start) begin
            for (int i = 0; i < T; i++) r_thread_pc[i] <= '0;
            r_live  <= w_live_init;
            r_k     <= '0;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                S_READY: begin
                    if (i_update) begin
                        // Only threads that executed current_pc report a new PC.
                        for (int i = 0; i < T; i++) begin
                            if (r_active_mask[i]) begin
                                if (i_thread_ret[i]) r_live[i]      <= 1'b0;
                                else                 r_thread_pc[i] <= i_thread_next_pc[i*A +: A];
                            end
                        end
                        r_k     <= '0;
                        r_found <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_k      <= r_k + 1'b1;
                    r_found  <= w_found_nxt;
                    r_min_pc <= w_min_nxt;
                    r_mask   <= w_mask_nxt;
                    if ((r_k == K_LAST) && w_found_nxt) begin
                        r_current_pc  <= w_min_nxt;
                        r_active_mask <= w_mask_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; current_pc/active_mask keep their last values while scanning.
    always_comb begin
        o_current_pc  = '0;
        o_active_mask = '0;
        o_pc_valid    = 1'b0;
        o_diverged    = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            S_SCAN: begin
                o_current_pc  = r_current_pc;
                o_active_mask = r_active_mask;
            end
            S_READY: begin
                o_current_pc  = r_current_pc;
                o_active_mask = r_active_mask;
                o_pc_valid    = 1'b1;
                o_diverged    = (r_active_mask != r_live);
            end
            S_DONE: begin
                o_current_pc  = r_current_pc;
                o_done        = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pc_reconverge.sv
// tb_pc_reconverge
//   Directed bench for pc_reconverge (T=4, A=8). Stimulus pushes the
//   hand-computed expected result of each launch/update into a queue; a
//   monitor pops and compares whenever pc_valid or done rises.
module tb_pc_reconverge;
    localparam int T = 4;
    localparam int A = 8;

    typedef struct {
        logic [A-1:0] pc;
        logic [T-1:0] mask;
        logic         div;
        logic         done;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [2:0]     thread_count = '0;
    logic           update = 1'b0;
    logic [T*A-1:0] next_pc = '0;
    logic [T-1:0]   ret = '0;
    logic [A-1:0]   current_pc;
    logic [T-1:0]   active_mask;
    logic           pc_valid;
    logic           diverged;
    logic           done;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_reconverge #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_start          (start),
        .i_thread_count   (thread_count),
        .i_update         (update),
        .i_thread_next_pc (next_pc),
        .i_thread_ret     (ret),
        .o_current_pc     (current_pc),
        .o_active_mask    (active_mask),
        .o_pc_valid       (pc_valid),
        .o_diverged       (diverged),
        .o_done           (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [A-1:0] pc, input logic [T-1:0] mask,
                                input logic div, input logic dn);
        exp_t e;
        e.pc = pc; e.mask = mask; e.div = div; e.done = dn;
        return e;
    endfunction

    // Monitor: compare against the scoreboard on each rising pc_valid/done.
    logic prev_valid = 1'b0;
    logic prev_done  = 1'b0;
    always @(negedge clk) begin
        if (!reset && ((pc_valid && !prev_valid) || (done && !prev_done))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {pc_valid, done}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done", done, e.done);
                check("pc_valid", pc_valid, !e.done);
                check("active_mask", active_mask, e.mask);
                if (!e.done) begin
                    check("current_pc", current_pc, e.pc);
                    check("diverged", diverged, e.div);
                end
            end
        end
        prev_valid = pc_valid;
        prev_done  = done;
    end

    // Each pulse returns on the falling edge right after the sampling edge.
    task automatic pulse_start(input logic [2:0] tc);
        @(negedge clk);
        start = 1'b1; thread_count = tc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_update(input logic [T*A-1:0] npc, input logic [T-1:0] r);
        @(negedge clk);
        update = 1'b1; next_pc = npc; ret = r;
        @(negedge clk);
        update = 1'b0;
    endtask

    // Wait (bounded) for pc_valid or done; check the number of falling edges.
    task automatic wait_result(input string name, input int exp_n);
        int n = 0;
        while (!(pc_valid || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_n);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pc", current_pc, 0);
        check("rst_mask", active_mask, 0);
        check("rst_valid", pc_valid, 0);
        check("rst_div", diverged, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Launch with 4 threads
        exp_q.push_back(mk(8'h00, 4'b1111, 1'b0, 1'b0));
        pulse_start(3'd4);
        wait_result("lat_start", T);

        // Uniform advance; old PC/mask held during the scan
        exp_q.push_back(mk(8'h01, 4'b1111, 1'b0, 1'b0));
        pulse_update({8'h01, 8'h01, 8'h01, 8'h01}, 4'b0000);
        check("hold_pc", current_pc, 8'h00);
        check("hold_mask", active_mask, 4'b1111);
        wait_result("lat_update", T);

        // Divergence
        exp_q.push_back(mk(8'h03, 4'b0011, 1'b1, 1'b0));
        pulse_update({8'h09, 8'h09, 8'h03, 8'h03}, 4'b0000);
        wait_result("lat_div", T);

        // Reconvergence; t2/t3 inputs ignored
        exp_q.push_back(mk(8'h09, 4'b1111, 1'b0, 1'b0));
        pulse_update({8'h55, 8'h55, 8'h09, 8'h09}, 4'b0000);
        wait_result("lat_reconv", T);

        // Update pulsed during SCAN is ignored
        exp_q.push_back(mk(8'h20, 4'b1111, 1'b0, 1'b0));
        pulse_update({8'h20, 8'h20, 8'h20, 8'h20}, 4'b0000);
        update = 1'b1; next_pc = {8'h77, 8'h77, 8'h77, 8'h77}; ret = 4'b1111;
        @(negedge clk);
        update = 1'b0; ret = 4'b0000;
        wait_result("lat_scan_upd", T - 1);

        // RET of t0
        exp_q.push_back(mk(8'h21, 4'b1110, 1'b0, 1'b0));
        pulse_update({8'h21, 8'h21, 8'h21, 8'h21}, 4'b0001);
        wait_result("lat_ret0", T);

        // Remaining threads return
        exp_q.push_back(mk(8'h00, 4'b0000, 1'b0, 1'b1));
        pulse_update({8'h30, 8'h30, 8'h30, 8'h30}, 4'b1110);
        wait_result("lat_done", T);

        // DONE holds and ignores update
        pulse_update({8'h40, 8'h40, 8'h40, 8'h40}, 4'b0000);
        repeat (T + 2) @(negedge clk);
        check("done_hold", done, 1'b1);
        check("done_no_valid", pc_valid, 1'b0);

        // Relaunch with 3 threads
        exp_q.push_back(mk(8'h00, 4'b0111, 1'b0, 1'b0));
        pulse_start(3'd3);
        wait_result("lat_tc3", T);

        // Thread 3 is not live even with next PC 0x00
        exp_q.push_back(mk(8'h05, 4'b0111, 1'b0, 1'b0));
        pulse_update({8'h00, 8'h05, 8'h05, 8'h05}, 4'b0000);
        wait_result("lat_tc3_upd", T);

        // Start during READY restarts at PC 0
        exp_q.push_back(mk(8'h00, 4'b0011, 1'b0, 1'b0));
        pulse_start(3'd2);
        wait_result("lat_restart", T);

        // thread_count = 0 goes straight to DONE
        exp_q.push_back(mk(8'h00, 4'b0000, 1'b0, 1'b1));
        pulse_start(3'd0);
        wait_result("lat_tc0", 0);

        // Reset mid-SCAN
        pulse_start(3'd4);
        reset = 1'b1;
        @(negedge clk);
        check("rst_scan_pc", current_pc, 0);
        check("rst_scan_mask", active_mask, 0);
        check("rst_scan_valid", pc_valid, 0);
        check("rst_scan_done", done, 0);
        reset = 1'b0;
        repeat (T + 2) @(negedge clk);
        check("idle_stays", {pc_valid, done}, 2'b00);

        // Unsigned compare: a wrapped PC of 0x00 runs first
        exp_q.push_back(mk(8'h00, 4'b1111, 1'b0, 1'b0));
        pulse_start(3'd4);
        wait_result("lat_wrap_start", T);
        exp_q.push_back(mk(8'h00, 4'b0010, 1'b1, 1'b0));
        pulse_update({8'h02, 8'hFF, 8'h00, 8'h80}, 4'b0000);
        wait_result("lat_wrap", T);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
